// File: rtl/psg_bus_sequencer_if.sv
// Purpose: request handshake plus AY-3-8913 bus pins between a host and the PSG bus sequencer.
// Latency: none. This is wiring only.
// Backpressure: req_ready is owned by the sequencer side. The host holds req_valid/addr/data until req_ready.
interface psg_bus_sequencer_if;
    // host -> sequencer write request
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_addr;
    logic [7:0] req_data;

    // sequencer -> PSG bus pins
    logic       bdir;
    logic       bc1;
    logic [7:0] da;

    // host / register-write source side
    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  bdir,
        input  bc1,
        input  da
    );

    // sequencer side
    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output bdir,
        output bc1,
        output da
    );
endinterface

// File: rtl/psg_bus_sequencer.sv
// Purpose: small generic FIFO used as the write-request queue, with occupancy output.
// Latency: one cycle from push to visibility on rd_vld/rd_dat. rd_dat is the head, shown combinationally.
// Backpressure: wr_rdy=0 whenever full, even if a pop happens in the same cycle.
module psg_bus_sequencer_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             push;
    logic             pop;

    // The extra pointer MSB tells full apart from empty when the index bits match.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_rdy = !full;
    assign rd_vld = (wr_ptr != rd_ptr);
    assign rd_dat = mem[rd_ptr[AW-1:0]];
    assign level  = wr_ptr - rd_ptr;
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    // Storage write. Contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    // Pointer update. Pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// Purpose: turns queued (addr,data) register writes into AY-3-8913 latch/write/gap bus cycles, in order.
// Latency: with defaults, a push at edge N shows LATCH after N+1, WRITE after N+2 and GAP after N+3. Throughput is 2*HOLD+GAP cycles per write.
// Backpressure: req_ready = FIFO not full. The host stalls while FIFO_DEPTH writes are queued.
module psg_bus_sequencer #(
    parameter logic [3:0] DA7_DA4_UPPER_ADDRESS_MASK = 4'b0000,
    parameter int         FIFO_DEPTH                 = 4,
    parameter int         HOLD_CYCLES                = 1,
    parameter int         GAP_CYCLES                 = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    psg_bus_sequencer_if.slave            bus,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          env_restart
);
    // Register index of the envelope-shape register. A completed write here restarts the envelope.
    localparam logic [3:0] ENV_SHAPE_ADDR = 4'd13;
    localparam bit         HAS_GAP        = (GAP_CYCLES != 0);
    // Counters count down to zero, so each phase loads (cycles - 1).
    localparam logic [7:0] HOLD_LOAD      = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD       = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] cur_addr;
    logic [7:0] cur_data;
    logic       bdir_q;
    logic       bc1_q;
    logic [7:0] da_q;

    req_t       req_in;
    req_t       head;
    logic       head_vld;
    logic       fifo_rdy;
    logic       cnt_done;
    logic       next_slot;
    logic       pop;

    assign req_in        = {bus.req_addr, bus.req_data};
    assign bus.req_ready = fifo_rdy;
    assign bus.bdir      = bdir_q;
    assign bus.bc1       = bc1_q;
    assign bus.da        = da_q;

    psg_bus_sequencer_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (bus.req_valid),
        .wr_rdy (fifo_rdy),
        .wr_dat (req_in),
        .rd_vld (head_vld),
        .rd_rdy (pop),
        .rd_dat (head),
        .level  (fifo_level)
    );

    // Decide when the bus is free to start the next transfer. Popping here keeps transfers back-to-back.
    always_comb begin
        cnt_done  = (cnt == 8'd0);
        next_slot = 1'b0;
        case (state)
            IDLE:    next_slot = 1'b1;
            WRITE:   next_slot = cnt_done && !HAS_GAP;
            GAP:     next_slot = cnt_done;
            default: next_slot = 1'b0;
        endcase
        pop  = head_vld && next_slot;
        busy = (state != IDLE) || (fifo_level != '0);
    end

    // Bus sequencing FSM. All pin outputs are registered, so they change only on clock edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            cur_addr    <= 4'd0;
            cur_data    <= 8'd0;
            bdir_q      <= 1'b0;
            bc1_q       <= 1'b0;
            da_q        <= 8'd0;
            env_restart <= 1'b0;
        end else begin
            // The pulse is aligned to the cycle right after the last WRITE cycle of an R13 transfer.
            env_restart <= (state == WRITE) && cnt_done && (cur_addr == ENV_SHAPE_ADDR);

            if (pop) begin
                // Start an address latch. This is the only place bc1 goes high.
                state    <= LATCH;
                cnt      <= HOLD_LOAD;
                cur_addr <= head.addr;
                cur_data <= head.data;
                bdir_q   <= 1'b1;
                bc1_q    <= 1'b1;
                da_q     <= {DA7_DA4_UPPER_ADDRESS_MASK, head.addr};
            end else begin
                case (state)
                    IDLE: begin
                        // Nothing queued. da keeps the last written value.
                        state <= IDLE;
                    end
                    LATCH: begin
                        if (cnt_done) begin
                            state <= WRITE;
                            cnt   <= HOLD_LOAD;
                            bc1_q <= 1'b0;
                            da_q  <= cur_data;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    WRITE: begin
                        if (cnt_done) begin
                            // Drop bdir. da keeps the data so the bus stays quiet.
                            bdir_q <= 1'b0;
                            if (HAS_GAP) begin
                                state <= GAP;
                                cnt   <= GAP_LOAD;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    GAP: begin
                        if (cnt_done) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        bdir_q <= 1'b0;
                        bc1_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Purpose: directed bench for psg_bus_sequencer with a write-order scoreboard on the default instance.
// Latency: checks exact cycle timing of LATCH/WRITE/GAP, env_restart and FIFO level.
// Backpressure: drives req_valid while honouring req_ready, and checks when ready must drop.
module tb_psg_bus_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a;
    logic       reset_b;
    logic       busy_a;
    logic       busy_b;
    logic       env_a;
    logic       env_b;
    logic [2:0] level_a;
    logic [2:0] level_b;

    psg_bus_sequencer_if bus_a ();
    psg_bus_sequencer_if bus_b ();

    psg_bus_sequencer dut_a (
        .clk         (clk),
        .reset       (reset_a),
        .bus         (bus_a),
        .busy        (busy_a),
        .fifo_level  (level_a),
        .env_restart (env_a)
    );

    psg_bus_sequencer #(
        .HOLD_CYCLES (3),
        .GAP_CYCLES  (0)
    ) dut_b (
        .clk         (clk),
        .reset       (reset_b),
        .bus         (bus_b),
        .busy        (busy_b),
        .fifo_level  (level_b),
        .env_restart (env_b)
    );

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one request whose acceptance is already known. The edge inside is "edge N".
    task automatic push_a(input logic [3:0] a, input logic [7:0] d);
        check("push_ready", 32'(bus_a.req_ready), 32'd1);
        bus_a.req_valid = 1'b1;
        bus_a.req_addr  = a;
        bus_a.req_data  = d;
        exp_q.push_back({a, d});
        tick();
        bus_a.req_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int max_cycles);
        int c = 0;
        while (busy_a && c < max_cycles) begin
            tick();
            c++;
        end
        check("idle_timeout", 32'(busy_a), 32'd0);
    endtask

    // Scoreboard monitor: on the first WRITE cycle, pair the latched address with da and compare against the queue.
    logic [3:0] lat_addr = 4'd0;
    logic       prev_wr  = 1'b0;
    always @(negedge clk) begin
        if (bus_a.bdir && bus_a.bc1) begin
            lat_addr = bus_a.da[3:0];
            check("latch_upper", 32'(bus_a.da[7:4]), 32'd0);
        end
        if (bus_a.bdir && !bus_a.bc1 && !prev_wr) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_unexpected: observed write 0x%0h expected none", {lat_addr, bus_a.da});
            end else begin
                check("sb_write", 32'({lat_addr, bus_a.da}), 32'(exp_q.pop_front()));
            end
        end
        prev_wr = bus_a.bdir && !bus_a.bc1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    bit         exp_rdy [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
    logic [3:0] t2_addr [7] = '{4'd0, 4'd1, 4'd14, 4'd15, 4'd8, 4'd3, 4'd9};
    logic [7:0] t2_data [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    logic [9:0] t4_exp  [4] = '{10'h304, 10'h2A5, 10'h306, 10'h25A};

    initial begin
        int  idx;
        int  cyc;
        bit  acc;

        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_addr = 4'd0; bus_a.req_data = 8'd0;
        bus_b.req_valid = 1'b0; bus_b.req_addr = 4'd0; bus_b.req_data = 8'd0;
        repeat (3) tick();

        // Reset state
        check("rst_bus",   32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'd0);
        check("rst_env",   32'(env_a), 32'd0);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_ready", 32'(bus_a.req_ready), 32'd1);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_b_bus", 32'({bus_b.bdir, bus_b.bc1, bus_b.da}), 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        tick();

        // Test 1: single R7=0x38 write with exact phase timing
        push_a(4'd7, 8'h38);
        check("t1_level", 32'(level_a), 32'd1);
        check("t1_busy",  32'(busy_a), 32'd1);
        tick();
        check("t1_latch", 32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h307);
        tick();
        check("t1_write", 32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h238);
        tick();
        check("t1_gap",   32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h038);
        check("t1_busy_gap", 32'(busy_a), 32'd1);
        tick();
        check("t1_idle",  32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h038);
        check("t1_idle_busy", 32'(busy_a), 32'd0);

        // Test 3: R13 gives one env_restart pulse in the cycle after WRITE. R12 gives none.
        push_a(4'd13, 8'h0E);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t3_env_r13", 32'(env_a), 32'(k == 3));
        end
        push_a(4'd12, 8'h0E);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t3_env_r12", 32'(env_a), 32'd0);
        end

        // Test 2: continuous pushes fill the FIFO. Ready drops at level 4, even while a pop is pending.
        idx = 0;
        cyc = 0;
        while (idx < 7 && cyc < 20) begin
            bus_a.req_valid = 1'b1;
            bus_a.req_addr  = t2_addr[idx];
            bus_a.req_data  = t2_data[idx];
            if (cyc < 9) check("t2_ready", 32'(bus_a.req_ready), 32'(exp_rdy[cyc]));
            if (cyc == 6) check("t2_full_level", 32'(level_a), 32'd4);
            if (cyc == 8) check("t2_pop_while_full_level", 32'(level_a), 32'd3);
            acc = bus_a.req_ready;
            if (acc) exp_q.push_back({t2_addr[idx], t2_data[idx]});
            tick();
            if (acc) idx++;
            cyc++;
        end
        bus_a.req_valid = 1'b0;
        check("t2_cycles", 32'(cyc), 32'd9);
        wait_idle_a(60);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Test 6: push and pop in the same cycle at level 2 keep the level at 2
        for (int k = 0; k < 3; k++) begin
            push_a(4'(k + 2), 8'(8'hA0 + k));
        end
        check("t6_level_pre", 32'(level_a), 32'd2);
        tick();
        check("t6_level_gap", 32'(level_a), 32'd2);
        check("t6_gap_bus",   32'({bus_a.bdir, bus_a.bc1}), 32'd0);
        push_a(4'd10, 8'hA3);
        check("t6_level_same", 32'(level_a), 32'd2);
        check("t6_latch_next", 32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h303);
        wait_idle_a(40);
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        // Test 5: reset during WRITE of R13 aborts, flushes the FIFO and gives no pulse
        push_a(4'd13, 8'h0F);
        push_a(4'd5, 8'h77);
        tick();
        check("t5_in_write", 32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h20F);
        check("t5_level_pre", 32'(level_a), 32'd1);
        reset_a = 1'b1;
        tick();
        exp_q.delete();
        check("t5_bus",   32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'd0);
        check("t5_level", 32'(level_a), 32'd0);
        check("t5_env",   32'(env_a), 32'd0);
        reset_a = 1'b0;
        tick();
        check("t5_env_after", 32'(env_a), 32'd0);
        push_a(4'd2, 8'h55);
        tick();
        check("t5_latch", 32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h302);
        tick();
        check("t5_write", 32'({bus_a.bdir, bus_a.bc1, bus_a.da}), 32'h255);
        wait_idle_a(10);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: HOLD=3, GAP=0 gives back-to-back LATCH/WRITE with no inactive cycle
        check("t4_ready0", 32'(bus_b.req_ready), 32'd1);
        bus_b.req_valid = 1'b1;
        bus_b.req_addr  = 4'd4;
        bus_b.req_data  = 8'hA5;
        tick();
        check("t4_ready1", 32'(bus_b.req_ready), 32'd1);
        bus_b.req_addr  = 4'd6;
        bus_b.req_data  = 8'h5A;
        tick();
        bus_b.req_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("t4_phase", 32'({bus_b.bdir, bus_b.bc1, bus_b.da}), 32'(t4_exp[k / 3]));
            tick();
        end
        check("t4_idle_bus", 32'({bus_b.bdir, bus_b.bc1, bus_b.da}), 32'h05A);
        check("t4_idle_busy", 32'(busy_b), 32'd0);
        check("t4_env", 32'(env_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
